// File: rtl/dual_branch_predictor_pkg.sv
// Shared definitions for the bimodal predictor: 2-bit counter encoding and reset state.
// Combinational-only content; no latency or flow control.
package bp_pkg;

    localparam int CTR_W = 2;

    typedef enum logic [CTR_W-1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_e;

    localparam ctr_state_e CTR_RESET = WNT;

endpackage

// File: rtl/dual_branch_predictor_if.sv
// Fetch-lookup, EX-training and perf-counter signals of the dual-issue branch predictor.
// Predictions are combinational; training is accepted every cycle, no backpressure.
interface dual_branch_predictor_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
);
    logic [PC_WIDTH-1:0]  pcF1;
    logic [PC_WIDTH-1:0]  pcF2;
    logic                 predictionF1;
    logic                 predictionF2;
    logic [PC_WIDTH-1:0]  pcE1;
    logic [PC_WIDTH-1:0]  pcE2;
    logic                 branchE1;
    logic                 branchE2;
    logic                 takenBranchE1;
    logic                 takenBranchE2;
    logic                 predictionE1;
    logic                 predictionE2;
    logic [CNT_WIDTH-1:0] branchCount;
    logic [CNT_WIDTH-1:0] mispredictCount;

    modport master (
        output pcF1, pcF2, pcE1, pcE2,
        output branchE1, branchE2, takenBranchE1, takenBranchE2,
        output predictionE1, predictionE2,
        input  predictionF1, predictionF2, branchCount, mispredictCount
    );

    modport slave (
        input  pcF1, pcF2, pcE1, pcE2,
        input  branchE1, branchE2, takenBranchE1, takenBranchE2,
        input  predictionE1, predictionE2,
        output predictionF1, predictionF2, branchCount, mispredictCount
    );
endinterface

// File: rtl/dual_branch_predictor_sat.sv
// 2-bit saturating counter next-state function (increment on taken, decrement otherwise).
// Purely combinational, zero latency, no backpressure.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_state_e state_i,
    input  logic       taken_i,
    output ctr_state_e next_o
);

    always_comb begin
        next_o = state_i;
        unique case (state_i)
            SNT: next_o = taken_i ? WNT : SNT;
            WNT: next_o = taken_i ? WT  : SNT;
            WT:  next_o = taken_i ? ST  : WNT;
            ST:  next_o = taken_i ? ST  : WT;
            default: next_o = state_i;
        endcase
    end

endmodule

// File: rtl/dual_branch_predictor.sv
// Bimodal BHT for two fetch slots, trained by both EX slots with slot-2 killed on a slot-1 mispredict.
// Lookup is combinational (0 cycles); training and perf counters update on the next edge, never stall.
module dual_branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int PC_WIDTH   = 32,
    parameter int IDX_LSB    = 0,
    parameter int CNT_WIDTH  = 32
) (
    input  logic clk,
    input  logic rst,
    dual_branch_predictor_if.slave bus
);

    localparam int NUM_ENTRIES = 1 << INDEX_BITS;

    typedef logic [INDEX_BITS-1:0] idx_t;

    ctr_state_e bht_q [NUM_ENTRIES];
    ctr_state_e bht_d [NUM_ENTRIES];

    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    idx_t idx_f1, idx_f2, idx_e1, idx_e2;

    // Upper PC bits alias by design; fold them here so they are visibly consumed.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pcF1, bus.pcF2, bus.pcE1, bus.pcE2};

    assign idx_f1 = bus.pcF1[IDX_LSB +: INDEX_BITS];
    assign idx_f2 = bus.pcF2[IDX_LSB +: INDEX_BITS];
    assign idx_e1 = bus.pcE1[IDX_LSB +: INDEX_BITS];
    assign idx_e2 = bus.pcE2[IDX_LSB +: INDEX_BITS];

    assign bus.predictionF1 = bht_q[idx_f1][1];
    assign bus.predictionF2 = bht_q[idx_f2][1];

    logic mis1, mis2, upd1, upd2, same_idx;

    assign mis1     = bus.branchE1 & (bus.predictionE1 ^ bus.takenBranchE1);
    assign upd1     = bus.branchE1;
    assign upd2     = bus.branchE2 & ~mis1;
    assign mis2     = upd2 & (bus.predictionE2 ^ bus.takenBranchE2);
    assign same_idx = (idx_e1 == idx_e2);

    ctr_state_e cur1, cur2, nxt1, nxt2;

    assign cur1 = bht_q[idx_e1];
    // Same-index pairs: slot 2 sees slot 1's result, giving sequential semantics in one edge.
    assign cur2 = (upd1 && same_idx) ? nxt1 : bht_q[idx_e2];

    sat_counter2 u_sat1 (
        .state_i (cur1),
        .taken_i (bus.takenBranchE1),
        .next_o  (nxt1)
    );

    sat_counter2 u_sat2 (
        .state_i (cur2),
        .taken_i (bus.takenBranchE2),
        .next_o  (nxt2)
    );

    always_comb begin
        bht_d = bht_q;
        if (upd1) bht_d[idx_e1] = nxt1;
        if (upd2) bht_d[idx_e2] = nxt2;
    end

    logic [1:0]         branch_inc, mispred_inc;
    logic [CNT_WIDTH:0] branch_sum, mispred_sum;

    assign branch_inc  = {1'b0, upd1} + {1'b0, upd2};
    assign mispred_inc = {1'b0, mis1} + {1'b0, mis2};
    assign branch_sum  = {1'b0, branch_cnt_q}  + (CNT_WIDTH+1)'(branch_inc);
    assign mispred_sum = {1'b0, mispred_cnt_q} + (CNT_WIDTH+1)'(mispred_inc);

    always_comb begin
        branch_cnt_d  = branch_sum[CNT_WIDTH]  ? '1 : branch_sum[CNT_WIDTH-1:0];
        mispred_cnt_d = mispred_sum[CNT_WIDTH] ? '1 : mispred_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                bht_q[i] <= CTR_RESET;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            bht_q         <= bht_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.branchCount     = branch_cnt_q;
    assign bus.mispredictCount = mispred_cnt_q;

endmodule

// File: tb/tb_dual_branch_predictor.sv
// Directed bench for dual_branch_predictor: reset, training, dual update, slot-2 kill, saturation, aliasing.
module tb_dual_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    dual_branch_predictor_if #(.PC_WIDTH(32), .CNT_WIDTH(32)) bus ();

    dual_branch_predictor #(
        .INDEX_BITS (6),
        .PC_WIDTH   (32),
        .IDX_LSB    (0),
        .CNT_WIDTH  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic [31:0] pc1, input logic b1, input logic t1, input logic p1,
                      input logic [31:0] pc2, input logic b2, input logic t2, input logic p2);
        bus.pcE1 = pc1; bus.branchE1 = b1; bus.takenBranchE1 = t1; bus.predictionE1 = p1;
        bus.pcE2 = pc2; bus.branchE2 = b2; bus.takenBranchE2 = t2; bus.predictionE2 = p2;
    endtask

    // One clock edge with the currently driven EX inputs, then clear them and settle.
    task automatic step();
        @(posedge clk);
        #1;
        ex(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    task automatic look(input logic [31:0] a, input logic [31:0] b);
        bus.pcF1 = a;
        bus.pcF2 = b;
        #1;
    endtask

    initial begin
        bus.pcF1 = 32'h0;
        bus.pcF2 = 32'h0;
        ex(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        look(32'h10, 32'h3F);
        chk("reset_predF1", 32'(bus.predictionF1), 32'd0);
        chk("reset_predF2", 32'(bus.predictionF2), 32'd0);
        chk("reset_bc", bus.branchCount, 32'd0);
        chk("reset_mc", bus.mispredictCount, 32'd0);

        // Training slot 1 at 0x10: mispredict, then correct
        ex(32'h10, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("train1_mc", bus.mispredictCount, 32'd1);
        chk("train1_bc", bus.branchCount, 32'd1);
        chk("train1_pred", 32'(bus.predictionF1), 32'd1);
        ex(32'h10, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("train2_mc", bus.mispredictCount, 32'd1);
        chk("train2_bc", bus.branchCount, 32'd2);
        chk("train2_pred", 32'(bus.predictionF1), 32'd1);

        // Same-index dual update at idx 5: 01 -T-> 10 -T-> 11
        ex(32'h5, 1'b1, 1'b1, 1'b1, 32'h5, 1'b1, 1'b1, 1'b1);
        step();
        look(32'h5, 32'h5);
        chk("dual_bc", bus.branchCount, 32'd4);
        chk("dual_predF1", 32'(bus.predictionF1), 32'd1);
        chk("dual_predF2", 32'(bus.predictionF2), 32'd1);
        // 11 -N-> 10 still predicts taken; a single-step 10 would fall to 01
        ex(32'h5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("dual_depth_pred", 32'(bus.predictionF1), 32'd1);
        chk("dual_depth_bc", bus.branchCount, 32'd5);

        // Idx 7: 01 -N-> 00, then same-index T,N: 00 -> 01 -> 00, then T -> 01
        ex(32'h7, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        ex(32'h7, 1'b1, 1'b1, 1'b1, 32'h7, 1'b1, 1'b0, 1'b0);
        step();
        chk("tn_bc", bus.branchCount, 32'd8);
        ex(32'h7, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        look(32'h7, 32'h7);
        chk("tn_pred", 32'(bus.predictionF1), 32'd0);
        chk("tn_mc", bus.mispredictCount, 32'd1);

        // Slot-2 kill: slot 1 mispredicts at 0x20, slot 2 branch at 0x21
        ex(32'h20, 1'b1, 1'b1, 1'b0, 32'h21, 1'b1, 1'b1, 1'b1);
        step();
        look(32'h20, 32'h21);
        chk("kill_bc", bus.branchCount, 32'd10);
        chk("kill_mc", bus.mispredictCount, 32'd2);
        chk("kill_slot1_pred", 32'(bus.predictionF1), 32'd1);
        chk("kill_slot2_pred", 32'(bus.predictionF2), 32'd0);

        // Saturation at 00: five not-taken at idx 0, then two taken
        for (int i = 0; i < 5; i++) begin
            ex(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            step();
        end
        chk("sat_bc", bus.branchCount, 32'd15);
        ex(32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        look(32'h0, 32'h40);
        chk("sat_t1_pred", 32'(bus.predictionF1), 32'd0);
        ex(32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("sat_t2_pred", 32'(bus.predictionF1), 32'd1);
        chk("alias_pred", 32'(bus.predictionF2), 32'd1);
        chk("sat_mc", bus.mispredictCount, 32'd4);

        // Non-branch slots leave state alone
        ex(32'h9, 1'b0, 1'b1, 1'b0, 32'h9, 1'b0, 1'b1, 1'b0);
        step();
        look(32'h9, 32'h9);
        chk("nobr_pred", 32'(bus.predictionF1), 32'd0);
        chk("nobr_bc", bus.branchCount, 32'd17);
        chk("nobr_mc", bus.mispredictCount, 32'd4);

        // Reset wins over a same-edge taken update to idx 0 (currently 10)
        rst = 1'b1;
        ex(32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        look(32'h0, 32'h10);
        chk("rst_mid_pred0", 32'(bus.predictionF1), 32'd0);
        chk("rst_mid_pred10", 32'(bus.predictionF2), 32'd0);
        chk("rst_mid_bc", bus.branchCount, 32'd0);
        chk("rst_mid_mc", bus.mispredictCount, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dual_branch_predictor.md
Name: dual_branch_predictor

Overview:
- Bimodal branch-history table (BHT) of 2-bit saturating counters for the dual-issue pipeline; upstream of hazard detection.
- In IF it looks up both fetch slots and supplies the per-slot predictions that travel down the pipe to become predictionE1/predictionE2.
- In EX it is trained by the resolved outcomes (branch, takenBranch, prediction) of both slots, under the same slot-2 kill rule the hazard unit uses for FlushEX2.
- Keeps saturating performance counters for branches and mispredictions.

Parameters:
- INDEX_BITS, 6, log2 of BHT entries (64 entries).
- PC_WIDTH, 32, width of fetch/execute PCs.
- IDX_LSB, 0, lowest PC bit used for indexing; 0 for word-addressed PCs.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pcF1  input  PC_WIDTH  fetch PC, slot 1.
- pcF2  input  PC_WIDTH  fetch PC, slot 2.
- predictionF1  output  1  predicted taken, slot 1 (combinational).
- predictionF2  output  1  predicted taken, slot 2 (combinational).
- pcE1  input  PC_WIDTH  PC of the EX-stage instruction, slot 1.
- pcE2  input  PC_WIDTH  PC of the EX-stage instruction, slot 2.
- branchE1  input  1  slot 1 in EX is a conditional branch.
- branchE2  input  1  slot 2 in EX is a conditional branch.
- takenBranchE1  input  1  resolved outcome, slot 1.
- takenBranchE2  input  1  resolved outcome, slot 2.
- predictionE1  input  1  prediction carried with slot 1.
- predictionE2  input  1  prediction carried with slot 2.
- branchCount  output  CNT_WIDTH  count of committed branch updates.
- mispredictCount  output  CNT_WIDTH  count of mispredicted branch updates.

Behaviour:
- Index: idx = pc[IDX_LSB+INDEX_BITS-1 : IDX_LSB]. Each BHT entry is a 2-bit counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup: predictionFn = bht[idx(pcFn)][1]. Purely combinational, zero latency, and unaffected by stalls.
- Read-during-write: a lookup returns the pre-edge value. There is no bypass from a same-cycle update.
- Update enables:
  - mis1 = branchE1 & (predictionE1 ^ takenBranchE1).
  - upd1 = branchE1.
  - upd2 = branchE2 & ~mis1. A slot-1 mispredict kills slot 2 (wrong path, consistent with FlushEX2), so slot 2 neither trains nor counts.
- Counter rule:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- Simultaneous updates:
  - Different indices: both entries update in the same edge.
  - Same index: slot 1 is applied first, then slot 2 to the result, all within one edge. Example: 01 with T,T gives 11; 11 with N,T gives 11; 00 with T,N gives 00.
- Performance counters:
  - branchCount += upd1 + upd2 (0, 1 or 2 per cycle).
  - mispredictCount += mis1 + (upd2 & (predictionE2 ^ takenBranchE2)).
  - Both saturate at all-ones; an increment of 2 at all-ones-minus-1 yields all-ones.
- Reset (rst=1 at an edge):
  - Every BHT entry becomes 01 (weakly not-taken), so predictionF1/F2 read 0 after reset.
  - branchCount and mispredictCount become 0.
  - Reset has priority over any same-cycle update.
- Non-branch slots (branchE=0): no state change, regardless of takenBranchE or predictionE.
- Aliasing: PCs differing only above the index bits share an entry; this is intended, with no tag check.

Decomposition:
- Shared package (bp_pkg): counter state constants SNT/WNT/WT/ST, the counter width (2), and the reset state WNT.
- Sub-module sat_counter2: combinational next-state function taking (state, taken) and returning next. It is instantiated twice and chained for the same-index case, so every update path uses one implementation.
- Performance counters stay inline.

Test Plan:
- Reset: hold rst 1 cycle, then lookup any pcF1/pcF2 -> predictionF1=predictionF2=0, branchCount=mispredictCount=0.
- Training: slot 1 branch at pcE1=0x10 taken with predictionE1=0, for 2 cycles. Expect mispredictCount=1 after cycle 1 (then 01->10, prediction flips). Cycle 2 predicts correctly (10->11, mispredictCount stays 1). Lookup pcF1=0x10 -> 1; branchCount=2.
- Same-index dual update: both slots at idx 5, entry 01, outcomes T and T, predictions correct as carried -> entry 11 after one edge; branchCount +2.
- Slot-2 kill: slot 1 mispredicts (branchE1=1, predictionE1=0, takenBranchE1=1) while slot 2 is a branch at a different index. Expect the slot-2 entry unchanged, branchCount +1, mispredictCount +1.
- Saturation and wrap: drive idx 0 not-taken 5 times -> stays 00. Drive pcF1=0x40 with INDEX_BITS=6 -> reads the same entry as pcF1=0x00.
- Reset mid-training: assert rst on the same edge as a taken update to an entry at 10 -> entry 01 and counters 0 afterwards.
